bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the four-digit seven-segment multiplexer. It takes a 14-bit unsigned binary value and produces four BCD digits on `bcd3`..`bcd0`. These ports connect straight to the multiplexer's `hex3`..`hex0` inputs. Conversion uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, with a start/ready/done handshake.

## Interface
- `BIN_W`, 14: binary input width; fixed at 14 in this revision.
- `DIGITS`, 4: BCD output digits; fixed at 4.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: conversion request; sampled only in IDLE.
- `bin` input 14: unsigned value; captured on the accepting edge only.
- `ready` output 1: high in IDLE (block can accept `start`).
- `done_tick` output 1: one-cycle pulse; the new result is valid on `bcd*`.
- `bcd3`..`bcd0` output 4 each: thousands, hundreds, tens and units digits; held stable between conversions.
- `ovf` output 1: input exceeded 9999. Driven only when `BIN2BCD_SAT_EN` is defined; otherwise tied to 0.

## Operation
- FSM with three states: IDLE, OP and DONE.
- Reset values:
  - state is IDLE, `ready`=1, `done_tick`=0.
  - all `bcd*` are 0, `ovf`=0.
  - working registers are 0 and the bit counter is 0.
- **IDLE → OP** when `start`=1:
  - load `bin` into the 14-bit shift register.
  - clear the four working BCD digits.
  - load the counter with 14.
- **OP** (one iteration per cycle):
  - each working digit > 4 has 3 added (4-bit, no carry out).
  - then {digits, shift register} shifts left by 1; the shift-register MSB enters the units digit LSB.
  - the thousands digit MSB shifted out is discarded.
  - the counter decrements.
  - when the counter reaches 1, the iteration completes, the final digits load into the `bcd*` output registers, and the FSM enters DONE.
- **DONE**: `done_tick`=1 for exactly this cycle; the FSM then returns unconditionally to IDLE.
- `start` in OP or DONE is ignored; no queuing.
- Output registers change only on OP→DONE and on reset. Working registers are never visible on ports.
- Out-of-range input (10000..16383) without the macro: the result is the value mod 10000. Example: 12345 gives 2,3,4,5.

## Timing
- Let edge E0 be the edge that samples `start`=1 in IDLE.
- `ready` goes low after E0.
- Edges E1..E14 perform the 14 iterations; outputs update at E14.
- `done_tick` is high between E14 and E15.
- `ready` is high again after E15.
- Accept-to-done latency is 14 cycles; throughput is one conversion per 16 cycles.
- `start` held high continuously re-triggers at every IDLE visit, i.e. every 16 cycles.
- Reset mid-conversion:
  - on the next edge, state is IDLE and all outputs return to reset values, including `bcd*`=0.
  - no `done_tick` is generated for the aborted conversion.
- Reset and `start` in the same cycle: reset wins and the `start` is dropped.

## Configuration
- `BIN2BCD_SAT_EN` defined:
  - the input is compared against 9999 at capture (E0) and the flag is registered.
  - at OP→DONE, if the flag is set, `bcd*` load 9,9,9,9 and `ovf`=1. Otherwise the converted digits load and `ovf`=0.
  - `ovf` holds until the next OP→DONE or reset.
  - latency is unchanged.
- Not defined: no comparator is built, `ovf` is constant 0, and mod-10000 behaviour applies.

## Structure
- Package `bin2bcd_pkg` holds:
  - `BIN_W`, `DIGITS`, and the iteration count (= `BIN_W`).
  - the counter width (4 bits).
  - the state encoding: IDLE=2'b00, OP=2'b01, DONE=2'b10.
  - the saturation limit constant 9999.
- One sub-module, `bcd_digit_adj`: combinational 4-bit "add 3 if > 4", instantiated `DIGITS` times.
- Everything else lives in `bin2bcd_seq`.

## Test plan
- **Reset, then `bin`=0 with a 1-cycle `start`:** `ready` drops after E0; `done_tick` is high only between E14 and E15; `bcd*`=0,0,0,0; `ready` is high after E15.
- **`bin`=1234, then `bin`=9999:** results 1,2,3,4 and then 9,9,9,9. Each is held unchanged until the next `done_tick`, and `ovf`=0.
- **`bin`=12345:**
  - without the macro: 2,3,4,5 with `ovf`=0.
  - with `BIN2BCD_SAT_EN`: 9,9,9,9 with `ovf`=1.
  - a following conversion of 42 gives 0,0,4,2 with `ovf`=0.
- **Start 500, then pulse `start` with `bin`=777 at E5 and again in the DONE cycle:** both pulses are ignored; result 0,5,0,0 with a single `done_tick`.
- **Start 4321, assert `reset` before E7:** `bcd*`=0 and `ready`=1 after the reset edge, with no `done_tick` in the following 20 cycles.
- **`start` held high, `bin` stepping 0..20 once per accepted conversion:** a `done_tick` every 16 cycles, each matching the decimal value captured at its E0.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_pkg
//  Purpose  : Shared widths, state encoding and constants for bin2bcd_seq.
//  Revision : 1.0  initial release
// ============================================================================
package bin2bcd_pkg;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int BCD_W  = DIGITS * 4;
    localparam int CNT_W  = 4;

    // One double-dabble iteration per input bit.
    localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(BIN_W);

    localparam logic [BIN_W-1:0] SAT_LIMIT = BIN_W'(9999);
    localparam logic [BCD_W-1:0] SAT_BCD   = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OP   = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage : bin2bcd_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_adj
//  Purpose  : Combinational double-dabble correction: add 3 when digit > 4.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // 4-bit wrap is intentional; legal BCD inputs never exceed 9.
    assign o_digit = (i_digit > 4'd4) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : 14-bit binary to 4-digit BCD, shift-and-add-3, one bit/clock.
//             Optional saturation to 9999 with ovf flag: BIN2BCD_SAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import bin2bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             ready,
    output logic             done_tick,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0,
    output logic             ovf
);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   work_q,  work_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;

    logic [BCD_W-1:0]   w_work_adj;
    logic [BCD_W-1:0]   w_work_next;
    logic [BIN_W-1:0]   w_shreg_next;

`ifdef BIN2BCD_SAT_EN
    logic               sat_q, sat_d;
    logic               ovf_q, ovf_d;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (work_q[4*gi +: 4]),
                .o_digit (w_work_adj[4*gi +: 4])
            );
        end
    endgenerate

    // Thousands-digit MSB falls off the top of the shift.
    assign w_work_next  = (w_work_adj << 1) | {{(BCD_W-1){1'b0}}, shreg_q[BIN_W-1]};
    assign w_shreg_next = shreg_q << 1;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
`ifdef BIN2BCD_SAT_EN
        sat_d   = sat_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_OP;
                    shreg_d = bin;
                    work_d  = '0;
                    cnt_d   = ITER_CNT;
`ifdef BIN2BCD_SAT_EN
                    sat_d   = (bin > SAT_LIMIT);
`endif
                end
            end
            ST_OP: begin
                shreg_d = w_shreg_next;
                work_d  = w_work_next;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
`ifdef BIN2BCD_SAT_EN
                    bcd_d   = sat_q ? SAT_BCD : w_work_next;
                    ovf_d   = sat_q;
`else
                    bcd_d   = w_work_next;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
`ifdef BIN2BCD_SAT_EN
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
`ifdef BIN2BCD_SAT_EN
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign done_tick = (state_q == ST_DONE);
    assign bcd3      = bcd_q[15:12];
    assign bcd2      = bcd_q[11:8];
    assign bcd1      = bcd_q[7:4];
    assign bcd0      = bcd_q[3:0];

endmodule : bin2bcd_seq
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin2bcd_seq
//  Purpose  : Self-checking bench for bin2bcd_seq against a decimal model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        ready, done_tick, ovf;
    logic [3:0]  bcd3, bcd2, bcd1, bcd0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;

    bin2bcd_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; everything after sits 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done_tick) done_cnt++;
    endtask

    function automatic int model_val(input int v);
`ifdef BIN2BCD_SAT_EN
        return (v > 9999) ? 9999 : v;
`else
        return v % 10000;
`endif
    endfunction

    function automatic logic [15:0] model_bcd(input int v);
        int x;
        x = model_val(v);
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic logic model_ovf(input int v);
`ifdef BIN2BCD_SAT_EN
        return (v > 9999);
`else
        return (v < 0);
`endif
    endfunction

    function automatic logic [15:0] dut_bcd();
        return {bcd3, bcd2, bcd1, bcd0};
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done_tick && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Full conversion from IDLE; returns with the FSM back in IDLE.
    task automatic run_conv(input int v);
        int lat;
        bin   = v[13:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        bin   = 14'($urandom);
        check("ready_low", 32'(ready), 32'd0);
        wait_done(lat);
        check("latency", 32'(lat), 32'd14);
        check("bcd", 32'(dut_bcd()), 32'(model_bcd(v)));
        check("ovf", 32'(ovf), 32'(model_ovf(v)));
        tick();
        check("done_pulse", 32'(done_tick), 32'd0);
        check("ready_back", 32'(ready), 32'd1);
    endtask

    initial begin : main
        int lat;
        int last_done;
        int dc0;
        logic [15:0] held;

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done_tick), 32'd0);
        check("rst_bcd", 32'(dut_bcd()), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        tick();

        // Zero, then known values with hold check
        run_conv(0);
        run_conv(1234);
        held = dut_bcd();
        for (int i = 0; i < 5; i++) tick();
        check("hold_1234", 32'(dut_bcd()), 32'(model_bcd(1234)));
        check("hold_same", 32'(dut_bcd()), 32'(held));
        run_conv(9999);
        run_conv(12345);
        run_conv(42);
        run_conv(16383);
        run_conv(10000);

        // Start pulses during OP and DONE must be ignored
        bin   = 14'd500;
        start = 1'b1;
        tick();
        start = 1'b0;
        dc0   = done_cnt;
        for (int i = 0; i < 4; i++) tick();
        bin   = 14'd777;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        check("ign_latency", 32'(lat + 5), 32'd14);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_ready", 32'(ready), 32'd1);
        check("ign_bcd", 32'(dut_bcd()), 32'(model_bcd(500)));
        for (int i = 0; i < 20; i++) tick();
        check("ign_single_done", 32'(done_cnt - dc0), 32'd1);

        // Reset mid-conversion aborts with no done_tick
        bin   = 14'd4321;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("abort_bcd", 32'(dut_bcd()), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_ovf", 32'(ovf), 32'd0);
        dc0 = done_cnt;
        for (int i = 0; i < 20; i++) tick();
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);

        // Randomised conversions with random idle gaps
        for (int n = 0; n < 12; n++) begin
            run_conv(int'($urandom_range(0, 16383)));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end

        // start held high: back-to-back conversions every 16 cycles
        last_done = -1;
        start = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            check("stream_ready", 32'(ready), 32'd1);
            bin = 14'(n);
            tick();
            bin = 14'(n + 100);
            wait_done(lat);
            check("stream_latency", 32'(lat), 32'd14);
            check("stream_bcd", 32'(dut_bcd()), 32'(model_bcd(n)));
            if (last_done >= 0) check("stream_period", 32'(cyc - last_done), 32'd16);
            last_done = cyc;
            tick();
        end
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bin2bcd_seq
`default_nettype wire
